// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game-flow FSM for the snake game (menu, level choice, lives, win/over, pause, high score)
module snake_game_ctrl #(
  parameter int MAX_LEN   = 10,
  parameter int WIN_LEN   = 10,
  parameter int LEVELS    = 3,
  parameter int LIVES     = 3,
  parameter int ROW_MAX   = 23,
  parameter int MENU_GAME = 2,
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int VW = $clog2(LIVES + 1),
  localparam int PW = $clog2(LEVELS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enter,
  input  logic                  esc,
  input  logic                  pause,
  input  logic [LEVELS-1:0]     level_sel,
  input  logic [4:0]            menu_state,
  input  logic                  tick,
  input  logic [LW-1:0]         length,
  input  logic [10*MAX_LEN-1:0] body,
  output logic [2:0]            state,
  output logic [PW-1:0]         level,
  output logic [LW-1:0]         score,
  output logic [LW-1:0]         best,
  output logic [VW-1:0]         lives,
  output logic                  respawn,
  output logic                  finish
);
  typedef enum logic [2:0] {
    S_INITIAL, S_GAMING, S_END, S_WIN, S_OVER, S_CHOOSE, S_PAUSE, S_RESPAWN
  } st_t;
  st_t cur, nxt;
  logic self_hit, coll, hit;
  logic [PW-1:0] sel_lvl;
  // Segments 1..3 can never touch the head, so the self-hit scan starts at 4.
  always_comb begin
    self_hit = 1'b0;
    for (int i = 4; i < MAX_LEN; i++)
      self_hit = self_hit | (LW'(i) < length && body[10*i +: 10] == body[9:0]);
    coll = tick && (self_hit || body[4:0] > 5'(ROW_MAX) ||
                    (body[9:5] == 5'd31 && body[19:15] == 5'd0) ||
                    (body[9:5] == 5'd0 && body[19:15] == 5'd31));
    hit = cur == S_GAMING && score != LW'(WIN_LEN) && score != '0 && coll;
  end
  always_comb begin
    sel_lvl = '0;
    for (int i = LEVELS - 1; i >= 0; i--)
      if (level_sel[i]) sel_lvl = PW'(i + 1);
  end
  always_ff @(posedge clk)
    cur <= rst ? S_INITIAL : nxt;
  always_comb begin
    nxt = cur;
    case (cur)
      S_INITIAL: nxt = enter && menu_state == 5'(MENU_GAME) ? S_CHOOSE : S_INITIAL;
      S_CHOOSE:  nxt = |level_sel ? S_GAMING : S_CHOOSE;
      S_GAMING:  nxt = score == LW'(WIN_LEN) ? S_WIN :
                       score == '0 ? S_OVER :
                       coll ? (lives <= VW'(1) ? S_OVER : S_RESPAWN) :
                       pause ? S_PAUSE : S_GAMING;
      S_RESPAWN: nxt = S_GAMING;
      S_PAUSE:   nxt = pause || enter ? S_GAMING : esc ? S_END : S_PAUSE;
      S_WIN:     nxt = esc ? S_END : S_WIN;
      S_OVER:    nxt = esc ? S_END : S_OVER;
      S_END:     nxt = S_INITIAL;
      default:   nxt = S_INITIAL;
    endcase
  end
  always_comb state = cur;
  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= '0;
      score   <= '0;
      best    <= '0;
      lives   <= '0;
      respawn <= 1'b0;
      finish  <= 1'b0;
    end else begin
      score   <= length;
      finish  <= cur == S_OVER;
      respawn <= nxt == S_RESPAWN || (cur == S_CHOOSE && nxt == S_GAMING);
      if (cur == S_INITIAL && nxt == S_CHOOSE) level <= '0;
      if (cur == S_CHOOSE && nxt == S_GAMING) begin
        level <= sel_lvl;
        lives <= VW'(LIVES);
      end
      if (hit && lives != '0) lives <= lives - 1'b1;
      if ((nxt == S_WIN || nxt == S_OVER) && nxt != cur && score > best) best <= score;
    end
  end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed scoreboard bench for snake_game_ctrl
module tb_snake_game_ctrl;
  localparam int MAX_LEN = 10;
  localparam int S = 0, L = 1, SC = 2, B = 3, V = 4, R = 5, F = 6;
  logic clk = 0, rst = 1, enter = 0, esc = 0, pause = 0, tick = 0;
  logic [2:0] level_sel = '0;
  logic [4:0] menu_state = 5'd2;
  logic [3:0] length = 4'd4;
  logic [10*MAX_LEN-1:0] body;
  logic [2:0] state;
  logic [1:0] level;
  logic [3:0] score, best;
  logic [1:0] lives;
  logic respawn, finish;
  int n_chk = 0, n_fail = 0;
  typedef struct {int sel; logic [31:0] v;} exp_t;
  exp_t q[$];
  string names[7] = '{"state", "level", "score", "best", "lives", "respawn", "finish"};

  snake_game_ctrl dut (
    .clk(clk), .rst(rst), .enter(enter), .esc(esc), .pause(pause),
    .level_sel(level_sel), .menu_state(menu_state), .tick(tick),
    .length(length), .body(body), .state(state), .level(level),
    .score(score), .best(best), .lives(lives), .respawn(respawn), .finish(finish)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(input int sel);
    return sel == S ? 32'(state) : sel == L ? 32'(level) : sel == SC ? 32'(score) :
           sel == B ? 32'(best) : sel == V ? 32'(lives) : sel == R ? 32'(respawn) : 32'(finish);
  endfunction

  task automatic ex(input int s, input int v);
    exp_t e;
    e.sel = s;
    e.v = 32'(v);
    q.push_back(e);
  endtask

  task automatic step;
    exp_t e;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      assert (obs(e.sel) === e.v) else begin
        n_fail++;
        $error("FAIL %s: got %0d expected %0d", names[e.sel], obs(e.sel), e.v);
      end
    end
  endtask

  task automatic dbody;
    for (int i = 0; i < MAX_LEN; i++) body[10*i +: 10] = {5'(i + 2), 5'd10};
  endtask

  task automatic reset_check;
    rst = 1;
    for (int i = 0; i < 7; i++) ex(i, 0);
    step;
    rst = 0;
  endtask

  task automatic start_game(input logic [2:0] ls, input int lvl);
    enter = 1;
    ex(S, 5); ex(L, 0);
    step;
    enter = 0;
    level_sel = ls;
    ex(S, 1); ex(L, lvl); ex(V, 3); ex(R, 1);
    step;
    level_sel = '0;
    ex(S, 1); ex(R, 0);
    step;
  endtask

  task automatic hit_row(input int es, input int ev);
    body[4:0] = 5'd24;
    tick = 1;
    ex(S, es); ex(V, ev); ex(R, es == 7 ? 1 : 0);
    step;
    tick = 0;
    dbody;
    if (es == 7) begin
      ex(S, 1); ex(R, 0);
      step;
    end
  endtask

  task automatic back_to_init;
    esc = 1;
    ex(S, 2);
    step;
    esc = 0;
    ex(S, 0);
    step;
  endtask

  initial begin
    dbody;
    reset_check;
    start_game(3'b010, 2);
    length = 4'd10;
    ex(S, 1); ex(SC, 10);
    step;
    ex(S, 3); ex(B, 10); ex(F, 0);
    step;
    back_to_init;
    ex(L, 2); ex(V, 3);
    step;
    length = 4'd4;
    start_game(3'b001, 1);
    hit_row(7, 2);
    hit_row(7, 1);
    hit_row(4, 0);
    ex(B, 10);
    ex(S, 4); ex(F, 1);
    step;
    esc = 1;
    ex(S, 2); ex(F, 1);
    step;
    esc = 0;
    ex(S, 0); ex(F, 0);
    step;
    start_game(3'b100, 3);
    length = 4'd6;
    ex(SC, 6);
    step;
    body[9:0] = body[59:50];
    ex(S, 1); ex(V, 3);
    step;
    tick = 1;
    ex(S, 7); ex(V, 2);
    step;
    tick = 0;
    dbody;
    ex(S, 1);
    step;
    body[9:0] = body[39:30];
    tick = 1;
    ex(S, 1); ex(V, 2);
    step;
    body[9:5] = 5'd31;
    body[19:15] = 5'd0;
    ex(S, 7); ex(V, 1);
    step;
    tick = 0;
    dbody;
    ex(S, 1);
    step;
    pause = 1;
    ex(S, 6);
    step;
    pause = 0;
    body[4:0] = 5'd30;
    tick = 1;
    ex(S, 6); ex(V, 1);
    step;
    tick = 0;
    dbody;
    pause = 1;
    ex(S, 1);
    step;
    pause = 0;
    reset_check;
    length = 4'd7;
    start_game(3'b001, 1);
    hit_row(7, 2);
    hit_row(7, 1);
    hit_row(4, 0);
    ex(B, 7);
    step;
    back_to_init;
    start_game(3'b010, 2);
    pause = 1;
    ex(S, 6); ex(B, 7);
    step;
    pause = 0;
    reset_check;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameters: MAX_LEN, default 10, body segments tracked; WIN_LEN, default 10, length that wins; LEVELS, default 3, selectable speed levels; LIVES, default 3, lives per game; ROW_MAX, default 23, last legal row; MENU_GAME, default 2, menu code selecting the game.
REQ-002 SHALL define LW = clog2(MAX_LEN+1) and VW = clog2(LIVES+1).
REQ-003 Port: clk  input  1  single clock; all logic on posedge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: enter, esc, pause  input  1 each  single-cycle key pulses.
REQ-006 Port: level_sel  input  LEVELS  one-hot level key pulses.
REQ-007 Port: menu_state  input  5  top-menu selection code.
REQ-008 Port: tick  input  1  snake-step strobe; body positions valid and updated this cycle.
REQ-009 Port: length  input  LW  current snake length.
REQ-010 Port: body  input  10*MAX_LEN  segment i at bits [10i+9:10i], {col[9:5], row[4:0]}, segment 0 = head.
REQ-011 Port: state  output  3  FSM state.
REQ-012 Port: level  output  clog2(LEVELS+1)  chosen level, 0 = none.
REQ-013 Port: score  output  LW  registered copy of length.
REQ-014 Port: best  output  LW  high score.
REQ-015 Port: lives  output  VW  remaining lives.
REQ-016 Port: respawn  output  1  one-cycle pulse requesting snake re-init.
REQ-017 Port: finish  output  1  registered game-over flag.

Function
REQ-018 States/encoding: INITIAL=0, GAMING=1, END=2, WIN=3, OVER=4, CHOOSE=5, PAUSE=6, RESPAWN=7; codes 7'... unused none; illegal values impossible.
REQ-019 score SHALL load length every cycle (1-cycle latency); FSM decisions use score, not length.
REQ-020 INITIAL -> CHOOSE when enter=1 and menu_state==MENU_GAME; level cleared to 0.
REQ-021 CHOOSE -> GAMING on any level_sel bit; level = index of lowest set bit + 1; lives loaded to LIVES; respawn pulsed same transition.
REQ-022 GAMING priority, highest first: score==WIN_LEN -> WIN; score==0 -> OVER; collision on tick -> RESPAWN or OVER; pause -> PAUSE; else stay.
REQ-023 Collision (evaluated only when tick=1): head==segment i for any i in 4..MAX_LEN-1 with i<length; head row > ROW_MAX; head col 31 with segment 1 col 0, or head col 0 with segment 1 col 31 (wrap crossing).
REQ-024 On collision: lives decrements; if resulting lives==0 -> OVER, else -> RESPAWN.
REQ-025 RESPAWN: respawn=1 for exactly that one cycle, then GAMING unconditionally.
REQ-026 PAUSE: tick and collisions ignored; pause or enter -> GAMING; esc -> END.
REQ-027 WIN/OVER -> END on esc; else hold.
REQ-028 END -> INITIAL after one cycle; level, lives unchanged until next CHOOSE.
REQ-029 best SHALL update to score on the cycle the FSM enters WIN or OVER if score > best; never decreases except on reset.
REQ-030 finish SHALL register (state==OVER): high one cycle after OVER entered, low one cycle after OVER left.
REQ-031 Simultaneous keys: in CHOOSE only level_sel acts; in GAMING win/over/collision beat pause.
REQ-032 lives SHALL never underflow; saturates at 0.

Reset
REQ-033 rst=1 at a clock edge: state=INITIAL, level=0, score=0, best=0, lives=0, respawn=0, finish=0; applies mid-game from any state, overriding all inputs that cycle.

Verification
REQ-034 rst, menu_state=2, enter pulse, level_sel=3'b010 -> CHOOSE then GAMING, level=2, lives=3, respawn one pulse.
REQ-035 GAMING, length 4->10 -> score=10 one cycle later, next edge WIN, best=10; esc -> END -> INITIAL.
REQ-036 GAMING, lives=3, tick with head row 24 -> RESPAWN, lives=2, respawn 1 cycle, back to GAMING; repeat twice -> OVER, lives=0, finish=1 one cycle later.
REQ-037 length=6, head==segment 5 with tick=0 -> no state change; same with tick=1 -> collision taken; head==segment 3 -> ignored.
REQ-038 GAMING, pause -> PAUSE; tick with head row 30 -> stays PAUSE, lives unchanged; pause -> GAMING.
REQ-039 rst asserted while in PAUSE with best=7 -> all outputs reset values next edge, best=0.
